// File: rtl/icache_refill_ctrl.sv
// Miss/refill controller for the 8-line, 4-word-per-line direct-mapped I-cache.
// On a miss it stalls fetch and reads the line from instruction memory, one word
// at a time, always starting at word 0. It then writes the assembled line into the
// cache for one cycle and allows one re-lookup cycle before it accepts a new miss.
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cache_hit,
    output logic                stall,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic                fill_valid,
    output logic [4*WORD_W-1:0] fill_line,
    output logic [ADDR_W-1:0]   fill_addr,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int BASE_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FILL   = 2'd2,
        RELOOK = 2'd3
    } state_t;

    state_t                   state;
    logic [1:0]               cnt;
    logic [BASE_W-1:0]        base;
    logic [3:0][WORD_W-1:0]   line_buf;
    logic                     miss;

    // The byte offset within a line does not matter, because refills always start at word 0
    logic unused_offset;
    assign unused_offset = ^cpu_addr[3:0];

    // A lookup is a miss only when it is a real fetch
    assign miss = lookup_valid & ~cache_hit;

    // Stall is combinational so the fetch stage freezes in the cycle the miss is seen
    assign stall = (state != IDLE) | miss;

    // The line buffer and the latched base drive the fill port directly
    assign fill_line = line_buf;
    assign fill_addr = {base, 4'b0000};

    // Refill FSM: all state and all outputs except stall are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            base       <= '0;
            line_buf   <= '0;
            fill_valid <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_valid <= 1'b0;
                    mem_req    <= 1'b0;
                    if (miss) begin
                        base     <= cpu_addr[ADDR_W-1:4];
                        cnt      <= 2'd0;
                        mem_req  <= 1'b1;
                        mem_addr <= {cpu_addr[ADDR_W-1:4], 4'b0000};
                        if (miss_count != {CNT_W{1'b1}})
                            miss_count <= miss_count + 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // Request and address stay stable until memory accepts the word
                    if (mem_ready) begin
                        line_buf[cnt] <= mem_rdata;
                        cnt           <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            mem_req    <= 1'b0;
                            fill_valid <= 1'b1;
                            state      <= FILL;
                        end else begin
                            mem_addr <= {base, cnt + 2'd1, 2'b00};
                        end
                    end
                end
                FILL: begin
                    fill_valid <= 1'b0;
                    state      <= RELOOK;
                end
                RELOOK: begin
                    // One cycle for the cache to re-evaluate the PC against the new line
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
